// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode sequencer: byte FIFO, E0/F0 prefix decode, held-key tracking, valid/ready events.
// Optional set-2 to ASCII lookup on evt_ascii_o when PS2_KEY_ASCII_EN is defined.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [7:0]       evt_code_o,
  output logic             evt_ext_o,
  output logic             evt_release_o,
  output logic             evt_repeat_o,
  output logic [7:0]       evt_ascii_o,
  output logic             held_valid_o,
  output logic [7:0]       held_code_o,
  output logic [CNT_W-1:0] press_count_o,
  output logic             fifo_overflow_o
);

  // state   | meaning
  // IDLE    | no prefix pending
  // EXT     | E0 seen
  // BRK     | F0 seen
  // EXT_BRK | E0 F0 seen
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic        full, empty, consume, push, drop;
  logic [7:0]  byte_head;

  state_t      state_q, state_d;
  logic        emit, emit_ext, emit_rel, match, rep;

  logic        evt_valid_q, evt_ext_q, evt_rel_q, evt_rep_q;
  logic [7:0]  evt_code_q;
  logic        held_valid_q, held_ext_q;
  logic [7:0]  held_code_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic        overflow_q;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign consume   = !empty && (!evt_valid_q || evt_ready_i);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push      = rx_valid_i && (!full || consume);
  assign drop      = rx_valid_i && full && !consume;
  assign byte_head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, consume})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (consume) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_rel = 1'b0;
    if (consume) begin
      case (state_q)
        IDLE: begin
          if (byte_head == 8'hE0)      state_d = EXT;
          else if (byte_head == 8'hF0) state_d = BRK;
          else                         emit = 1'b1;
        end
        EXT: begin
          if (byte_head == 8'hF0)      state_d = EXT_BRK;
          else if (byte_head == 8'hE0) state_d = EXT;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (byte_head != 8'hE0 && byte_head != 8'hF0) begin
            emit     = 1'b1;
            emit_rel = 1'b1;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (byte_head != 8'hE0 && byte_head != 8'hF0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign match = held_valid_q && ({emit_ext, byte_head} == {held_ext_q, held_code_q});
  assign rep   = !emit_rel && match;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_ext_q    <= 1'b0;
      evt_rel_q    <= 1'b0;
      evt_rep_q    <= 1'b0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= '0;
      press_cnt_q  <= '0;
    end else begin
      if (emit) begin
        evt_valid_q <= 1'b1;
        evt_code_q  <= byte_head;
        evt_ext_q   <= emit_ext;
        evt_rel_q   <= emit_rel;
        evt_rep_q   <= rep;
        if (!emit_rel && !match) begin
          press_cnt_q  <= press_cnt_q + 1'b1;
          held_valid_q <= 1'b1;
          held_ext_q   <= emit_ext;
          held_code_q  <= byte_head;
        end else if (emit_rel && match) begin
          held_valid_q <= 1'b0;
          held_ext_q   <= 1'b0;
          held_code_q  <= '0;
        end
      end else if (evt_valid_q && evt_ready_i) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

`ifdef PS2_KEY_ASCII_EN
  logic [7:0] evt_ascii_q;

  function automatic logic [7:0] set2_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (!resetn_i)  evt_ascii_q <= '0;
    else if (emit)  evt_ascii_q <= emit_ext ? 8'h00 : set2_ascii(byte_head);
  end

  assign evt_ascii_o = evt_ascii_q;
`else
  assign evt_ascii_o = 8'h00;
`endif

  assign evt_valid_o     = evt_valid_q;
  assign evt_code_o      = evt_code_q;
  assign evt_ext_o       = evt_ext_q;
  assign evt_release_o   = evt_rel_q;
  assign evt_repeat_o    = evt_rep_q;
  assign held_valid_o    = held_valid_q;
  assign held_code_o     = held_code_q;
  assign press_count_o   = press_cnt_q;
  assign fifo_overflow_o = overflow_q;

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sequences the raw byte stream from the PS/2 frame receiver into keyboard key events.
- Buffers received bytes in a small FIFO and decodes the E0 (extended) and F0 (break) prefixes with an FSM.
- Tracks the currently held key, suppresses typematic repeats from the press counter, and presents one event at a time to the display/console logic over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8: byte FIFO entries; power of 2, minimum 2.
- CNT_W, 8: width of the key-press counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- rx_valid  in  1  one-cycle pulse; a frame with good start, stop and parity bits was received.
- rx_data  in  8  received scancode byte; valid with rx_valid.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_code  out  8  scancode of the event (prefixes stripped).
- evt_ext  out  1  event was E0-prefixed.
- evt_release  out  1  1 = break (key up), 0 = make.
- evt_repeat  out  1  make event for the key already held (typematic).
- evt_ascii  out  8  ASCII of evt_code (see Optional Feature).
- held_valid  out  1  a key is currently held.
- held_code  out  8  code of the held key.
- press_count  out  CNT_W  number of non-repeat make events, wraps modulo 2^CNT_W.
- fifo_overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset: synchronous; only when resetn=0 at a clk edge. It clears the FIFO pointers and count, sets FSM=IDLE, and drives all outputs to 0.
- Reset mid-sequence (e.g. after F0) discards the pending prefix.

FIFO:
- Push on rx_valid when not full.
- When full, rx_valid drops the byte and sets fifo_overflow (cleared only by reset).
- Pop happens when the FSM consumes a byte. Consumption requires a non-empty FIFO and no event held (evt_valid=0), or the held event being accepted that same cycle.
- Push and pop in the same cycle are both performed, including when the FIFO is full.
- Pointers wrap at FIFO_DEPTH.
- Latency: a byte pushed at cycle N can be consumed no earlier than cycle N+1.

FSM states IDLE, EXT, BRK, EXT_BRK. For each consumed byte b:
- IDLE: b=E0 goes to EXT; b=F0 goes to BRK; any other b emits a make event with ext=0 and stays in IDLE.
- EXT: b=F0 goes to EXT_BRK; b=E0 stays in EXT; any other b emits a make event with ext=1 and goes to IDLE.
- BRK: b=E0 or b=F0 is an error; go to IDLE with no event. Any other b emits a break event with ext=0 and goes to IDLE.
- EXT_BRK: b=E0 or b=F0 is an error; go to IDLE with no event. Any other b emits a break event with ext=1 and goes to IDLE.

Event emission:
- evt_* outputs are registered and rise the cycle after consumption.
- Once evt_valid=1, the evt_* fields remain stable until evt_valid && evt_ready.
- evt_valid drops the cycle after acceptance unless the next event is emitted in the acceptance cycle (back-to-back throughput of 1 event per cycle).

Held-key tracking:
- Make when held_valid=1 and {ext, code} equals the held key: evt_repeat=1, press_count unchanged.
- Any other make: evt_repeat=0, press_count+1, held updated to this key, held_valid=1.
- Break matching the held key: held_valid=0 and held_code=0.
- Break not matching the held key: the event is still emitted, held is unchanged.
- Held and counter updates occur on the emission cycle, not on acceptance.
- Held identity compares {ext, code}. The held ext bit is internal.

Optional Feature:
- Macro PS2_KEY_ASCII_EN.
- Defined: evt_ascii is registered alongside evt_code. It is a lookup of non-extended make/break codes to lowercase ASCII for set-2 letters and digits; for example 1C->61 'a', 32->62 'b', 16->31 '1', 45->30 '0', 29->20 space, 5A->0D enter. Unmapped or extended codes give 00.
- Not defined: evt_ascii is tied to 0 and no table logic is synthesized.

Test Plan:
- Byte 1C with evt_ready=1 -> one event: code=1C, ext=0, release=0, repeat=0. Then press_count=1, held_valid=1, held_code=1C, evt_ascii=61 (feature on) or 00 (feature off).
- Bytes 1C, F0, 1C -> two events (make, then break code=1C). Then held_valid=0 and press_count=1.
- Bytes E0, 75, E0, F0, 75 -> make and break events with ext=1 and code=75; no event is emitted for prefix bytes.
- Bytes 1C, 1C, 1C, then 32 -> events repeat=0,1,1,0. press_count=2; held_code=32.
- Hold evt_ready=0 and pulse 10 bytes 1C on consecutive cycles -> one event held stable. FIFO full, fifo_overflow=1, and the excess bytes are lost. After releasing ready, the remaining 8 buffered events drain one per cycle.
- Bytes F0 then resetn=0 for 1 cycle, then byte 1C -> the event is a make (release=0) and press_count=1.
